// File: rtl/ccu_round_sequencer_if.sv
// rtl/ccu_round_sequencer_if.sv - load and result nibble streams of the ccu round sequencer
interface ccu_round_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_key;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ccu_round_sequencer.sv
// rtl/ccu_round_sequencer.sv - nibble-serial load/run/drain sequencer around the 4-bit ccu datapath
module ccu_round_sequencer #(
    parameter int NIBBLES    = 4,
    parameter int NUM_ROUNDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ccu_round_sequencer_if.slave  bus,
    output logic                  busy,
    output logic [3:0]            round_idx,
    output logic                  ccu_en,
    output logic [3:0]            ccu_din,
    output logic [3:0]            ccu_kin,
    input  logic [3:0]            ccu_dout
);
    localparam int BW = 4 * NIBBLES;
    localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int LW = $clog2(BW);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [BW-1:0] state_q, state_d;
    logic [BW-1:0] key_q, key_d;
    logic [NW-1:0] nib_q, nib_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [3:0]    rnd_inc;
    logic [LW-1:0] nib_lsb;
    logic          nib_last;

    // Nibble 0 is the most significant nibble of the block.
    assign nib_lsb  = LW'((NIBBLES - 1 - int'(nib_q)) * 4);
    assign nib_last = (nib_q == NW'(NIBBLES - 1));
    assign rnd_inc  = rnd_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= LOAD;
            state_q <= '0;
            key_q   <= '0;
            nib_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            nib_q   <= nib_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        key_d         = key_q;
        nib_d         = nib_q;
        rnd_d         = rnd_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 4'd0;
        busy          = 1'b1;
        round_idx     = 4'd0;
        ccu_en        = 1'b0;
        ccu_din       = 4'd0;
        ccu_kin       = 4'd0;
        case (fsm_q)
            LOAD: begin
                busy         = 1'b0;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = {state_q[BW-5:0], bus.in_data};
                    key_d   = {key_q[BW-5:0], bus.in_key};
                    if (nib_last) begin
                        nib_d = '0;
                        rnd_d = 4'd0;
                        fsm_d = RUN;
                    end else begin
                        nib_d = nib_q + 1'b1;
                    end
                end
            end
            RUN: begin
                ccu_en                 = 1'b1;
                round_idx              = rnd_q;
                ccu_din                = state_q[nib_lsb +: 4];
                ccu_kin                = key_q[nib_lsb +: 4];
                state_d[nib_lsb +: 4]  = ccu_dout;
                if (nib_last) begin
                    // Key schedule: rotate left one nibble, fold in the next round number.
                    key_d = {key_q[BW-5:0], key_q[BW-1:BW-4]} ^ BW'(rnd_inc);
                    nib_d = '0;
                    if (rnd_q == 4'(NUM_ROUNDS - 1)) begin
                        fsm_d = DRAIN;
                    end else begin
                        rnd_d = rnd_inc;
                    end
                end else begin
                    nib_d = nib_q + 1'b1;
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = state_q[BW-1 -: 4];
                if (bus.out_ready) begin
                    state_d = state_q << 4;
                    if (nib_last) begin
                        nib_d = '0;
                        key_d = '0;
                        fsm_d = LOAD;
                    end else begin
                        nib_d = nib_q + 1'b1;
                    end
                end
            end
            default: begin
                fsm_d = LOAD;
                nib_d = '0;
                rnd_d = 4'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_ccu_round_sequencer.sv
// tb/tb_ccu_round_sequencer.sv - randomized self-checking bench for ccu_round_sequencer
module tb_ccu_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ccu_round_sequencer_if if4();
    ccu_round_sequencer_if if1();

    logic       busy4, ccu_en4, busy1, ccu_en1;
    logic [3:0] rnd4, din4, kin4, dout4, rnd1, din1, kin1, dout1;

    assign dout4 = din4 ^ kin4;
    assign dout1 = din1 ^ kin1;

    ccu_round_sequencer #(.NIBBLES(4), .NUM_ROUNDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave), .busy(busy4), .round_idx(rnd4),
        .ccu_en(ccu_en4), .ccu_din(din4), .ccu_kin(kin4), .ccu_dout(dout4)
    );

    ccu_round_sequencer #(.NIBBLES(4), .NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .round_idx(rnd1),
        .ccu_en(ccu_en1), .ccu_din(din1), .ccu_kin(kin1), .ccu_dout(dout1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rk [16];
    logic [15:0] rs [16];

    function automatic logic [3:0] nib(input logic [15:0] w, input int n);
        return w[4*(3-n) +: 4];
    endfunction

    // Block-level reference: with an XOR ccu each round is state ^= round key.
    task automatic model(input logic [15:0] d, input logic [15:0] k, input int rounds,
                         output logic [15:0] res);
        for (int r = 0; r < rounds; r++) begin
            rs[r] = d;
            rk[r] = k;
            d = d ^ k;
            k = {k[11:0], k[15:12]} ^ 16'(r + 1);
        end
        res = d;
    endtask

    task automatic run_block(input logic [15:0] d, input logic [15:0] k, input bit load_stall,
                             input int bp, input bit junk, input int abort_at, input string tag,
                             output logic [15:0] got);
        logic [15:0] expv;
        int i, guard, lat;
        bit done;
        model(d, k, 4, expv);
        got = '0;
        i = 0;
        guard = 0;
        while (i < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            if4.in_valid = load_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if4.in_data  = if4.in_valid ? nib(d, i) : 4'($urandom);
            if4.in_key   = if4.in_valid ? nib(k, i) : 4'($urandom);
            if (if4.in_valid && if4.in_ready) i++;
        end
        vectors++;
        if (i !== 4) begin
            miscompares++;
            $display("FAIL %s load_timeout: beats %0d required 4", tag, i);
        end
        lat = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if4.in_valid = junk;
                if4.in_data  = 4'($urandom);
                if4.in_key   = 4'($urandom);
            end
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                vectors++;
                if ({if4.in_ready, if4.out_valid, busy4, ccu_en4, rnd4, if4.out_data, din4, kin4}
                    !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
                    miscompares++;
                    $display("FAIL %s async_reset_outputs: got %h required %h", tag,
                             {if4.in_ready, if4.out_valid, busy4, ccu_en4, rnd4, if4.out_data, din4, kin4},
                             {4'b1000, 16'h0000});
                end
                if4.in_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (if4.out_valid) begin
                done = 1'b1;
                lat = c;
            end else if (c < 16) begin
                vectors++;
                if ({ccu_en4, rnd4, kin4, din4, if4.in_ready, busy4} !==
                    {1'b1, 4'(c / 4), nib(rk[c/4], c % 4), nib(rs[c/4], c % 4), 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL %s run_cycle_%0d {en,rnd,kin,din,rdy,busy}: got %h required %h", tag, c,
                             {ccu_en4, rnd4, kin4, din4, if4.in_ready, busy4},
                             {1'b1, 4'(c / 4), nib(rk[c/4], c % 4), nib(rs[c/4], c % 4), 1'b0, 1'b1});
                end
            end
        end
        vectors++;
        if (lat !== 16) begin
            miscompares++;
            $display("FAIL %s out_valid_latency: got %0d required 16", tag, lat);
        end
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < bp; s++) begin
                if4.out_ready = 1'b0;
                vectors++;
                if ({if4.out_valid, if4.out_data, if4.in_ready} !== {1'b1, nib(expv, b), 1'b0}) begin
                    miscompares++;
                    $display("FAIL %s drain_hold_%0d: got %h required %h", tag, b,
                             {if4.out_valid, if4.out_data, if4.in_ready}, {1'b1, nib(expv, b), 1'b0});
                end
                @(negedge clk);
            end
            vectors++;
            if ({if4.out_valid, if4.in_ready} !== 2'b10) begin
                miscompares++;
                $display("FAIL %s drain_beat_%0d {valid,ready}: got %b required 10", tag, b,
                         {if4.out_valid, if4.in_ready});
            end
            got = {got[11:0], if4.out_data};
            if4.out_ready = 1'b1;
            if (b == 3) if4.in_valid = 1'b0;
            @(negedge clk);
            if4.out_ready = 1'b0;
        end
        vectors++;
        if ({if4.out_valid, busy4, if4.in_ready, ccu_en4} !== 4'b0010) begin
            miscompares++;
            $display("FAIL %s post_drain {valid,busy,rdy,en}: got %b required 0010", tag,
                     {if4.out_valid, busy4, if4.in_ready, ccu_en4});
        end
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s result: got %h required %h", tag, got, expv);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({if4.in_ready, if4.out_valid, busy4, ccu_en4, rnd4, din4, kin4, if4.out_data, if1.in_ready, busy1}
                !== {4'b1000, 16'h0000, 2'b10}) begin
                miscompares++;
                $display("FAIL reset_idle_%0d: got %h required %h", c,
                         {if4.in_ready, if4.out_valid, busy4, ccu_en4, rnd4, din4, kin4, if4.out_data, if1.in_ready, busy1},
                         {4'b1000, 16'h0000, 2'b10});
            end
        end
    endtask

    task automatic test_single_round;
        logic [15:0] got;
        int i, guard, en_cnt, lat;
        i = 0;
        guard = 0;
        while (i < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if1.in_valid = 1'b1;
            if1.in_data  = nib(16'h1234, i);
            if1.in_key   = nib(16'h00FF, i);
            if (if1.in_ready) i++;
        end
        en_cnt = 0;
        lat = 0;
        for (int c = 0; c < 32 && lat == 0; c++) begin
            @(negedge clk);
            if1.in_valid = 1'b0;
            if (ccu_en1) en_cnt++;
            if (if1.out_valid) lat = c;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL single_latency: got %0d required 4", lat);
        end
        vectors++;
        if (en_cnt !== 4) begin
            miscompares++;
            $display("FAIL single_ccu_en_cycles: got %0d required 4", en_cnt);
        end
        got = '0;
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if (if1.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL single_out_valid_%0d: got %b required 1", b, if1.out_valid);
            end
            got = {got[11:0], if1.out_data};
            if1.out_ready = 1'b1;
            @(negedge clk);
            if1.out_ready = 1'b0;
        end
        vectors++;
        if (got !== 16'h12CB) begin
            miscompares++;
            $display("FAIL single_result: got %h required 12cb", got);
        end
        vectors++;
        if ({if1.out_valid, busy1} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_post_drain: got %b required 00", {if1.out_valid, busy1});
        end
    endtask

    task automatic test_default_rounds;
        logic [15:0] got;
        run_block(16'h1234, 16'h00FF, 1'b0, 0, 1'b0, -1, "default", got);
        vectors++;
        if (got !== 16'h1304) begin
            miscompares++;
            $display("FAIL default_known_answer: got %h required 1304", got);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] got;
        run_block(16'h1234, 16'h00FF, 1'b0, 5, 1'b1, -1, "backpressure", got);
        vectors++;
        if (got !== 16'h1304) begin
            miscompares++;
            $display("FAIL backpressure_known_answer: got %h required 1304", got);
        end
    endtask

    task automatic test_load_stalls;
        logic [15:0] got;
        run_block(16'h1234, 16'h00FF, 1'b1, 0, 1'b0, -1, "load_stalls", got);
        vectors++;
        if (got !== 16'h1304) begin
            miscompares++;
            $display("FAIL load_stalls_known_answer: got %h required 1304", got);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] got;
        run_block(16'hBEEF, 16'hC0DE, 1'b0, 0, 1'b1, 7, "reset_mid", got);
        run_block(16'h1234, 16'h00FF, 1'b0, 0, 1'b0, -1, "after_reset", got);
        vectors++;
        if (got !== 16'h1304) begin
            miscompares++;
            $display("FAIL after_reset_known_answer: got %h required 1304", got);
        end
    endtask

    task automatic test_random;
        logic [15:0] got;
        for (int n = 0; n < 8; n++) begin
            run_block(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), -1, $sformatf("random_%0d", n), got);
        end
    endtask

    initial begin
        if4.in_valid = 1'b0; if4.in_data = 4'd0; if4.in_key = 4'd0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = 4'd0; if1.in_key = 4'd0; if1.out_ready = 1'b0;
        test_reset();
        test_single_round();
        test_default_rounds();
        test_backpressure();
        test_load_stalls();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
